// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// trace_capture : cycle-tagged capture FIFO (first-word fall-through) with MISR
// Revision 1.0
// ============================================================================
module trace_capture #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned TAG_W        = 32,
  parameter bit          STOP_ON_FULL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          obs,
  input  logic [127:0]                  out_data,
  input  logic [63:0]                   cap,
  input  logic                          freeze,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [TAG_W+191:0]            rd_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic [15:0]                   drops,
  output logic [127:0]                  signature,
  output logic                          frozen
);

  localparam int unsigned c_AW = $clog2(DEPTH);
  localparam int unsigned c_CW = c_AW + 1;
  localparam int unsigned c_EW = TAG_W + 192;

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_FROZEN = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [c_EW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [TAG_W-1:0]  r_tag;
  logic              r_overflow;
  logic [15:0]       r_drops;
  logic [127:0]      r_sig;

  logic              w_pop;
  logic              w_full;
  logic              w_accept;
  logic              w_drop;
  logic [127:0]      w_sig_next;

  assign w_pop  = (r_count != '0) && rd_ready;
  assign w_full = (r_count == c_CW'(DEPTH));

  // A full buffer still accepts when the head is popped in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (obs) begin
          if (!w_full || w_pop) begin
            w_accept = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
        if (freeze || (w_drop && STOP_ON_FULL)) begin
          w_state_next = S_FROZEN;
        end
      end
      S_FROZEN: begin
        w_state_next = S_FROZEN;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  assign w_sig_next = {r_sig[126:0], 1'b0} ^ (r_sig[127] ? 128'h87 : 128'h0) ^ out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tag      <= '0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
      r_sig      <= '0;
    end else begin
      r_state <= w_state_next;
      r_tag   <= r_tag + TAG_W'(1);
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
        r_sig    <= w_sig_next;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != 16'hFFFF) begin
          r_drops <= r_drops + 16'd1;
        end
      end
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_mem[r_wr_ptr] <= {r_tag, out_data, cap};
    end
  end

  assign rd_valid  = (r_count != '0);
  assign rd_data   = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drops     = r_drops;
  assign signature = r_sig;
  assign frozen    = (r_state == S_FROZEN);

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// tb_trace_capture : two instances (STOP_ON_FULL 0/1) on shared stimulus,
// checked every cycle against a queue-based reference model plus directed checks.
module tb_trace_capture;

  localparam int unsigned c_DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst, obs, freeze, rd_ready;
  logic [127:0] out_data;
  logic [63:0]  cap;

  logic         rd_valid0, rd_valid1;
  logic [223:0] rd_data0, rd_data1;
  logic [3:0]   count0, count1;
  logic         overflow0, overflow1;
  logic [15:0]  drops0, drops1;
  logic [127:0] signature0, signature1;
  logic         frozen0, frozen1;

  int checks = 0;
  int errors = 0;

  trace_capture #(.DEPTH(c_DEPTH), .TAG_W(32), .STOP_ON_FULL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .obs(obs), .out_data(out_data), .cap(cap),
    .freeze(freeze), .rd_ready(rd_ready), .rd_valid(rd_valid0), .rd_data(rd_data0),
    .count(count0), .overflow(overflow0), .drops(drops0), .signature(signature0),
    .frozen(frozen0)
  );

  trace_capture #(.DEPTH(c_DEPTH), .TAG_W(32), .STOP_ON_FULL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .obs(obs), .out_data(out_data), .cap(cap),
    .freeze(freeze), .rd_ready(rd_ready), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .count(count1), .overflow(overflow1), .drops(drops1), .signature(signature1),
    .frozen(frozen1)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 free-running on overflow, index 1 stops on overflow.
  logic [223:0] mq [2][$];
  logic         movf   [2];
  int unsigned  mdrops [2];
  logic [127:0] msig   [2];
  logic         mfrz   [2];
  logic [31:0]  mtag;

  function automatic logic [127:0] misr(input logic [127:0] s, input logic [127:0] d);
    logic [127:0] t;
    t = s << 1;
    if (s[127]) t = t ^ 128'h87;
    return t ^ d;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        movf[k] = 1'b0; mdrops[k] = 0; msig[k] = '0; mfrz[k] = 1'b0;
      end else begin
        bit pop, acc, drp;
        pop = (mq[k].size() != 0) && rd_ready;
        acc = 1'b0; drp = 1'b0;
        if (!mfrz[k] && obs) begin
          if (mq[k].size() < c_DEPTH || pop) acc = 1'b1;
          else drp = 1'b1;
        end
        if (pop) void'(mq[k].pop_front());
        if (acc) begin
          mq[k].push_back({mtag, out_data, cap});
          msig[k] = misr(msig[k], out_data);
        end
        if (drp) begin
          movf[k] = 1'b1;
          if (mdrops[k] < 65535) mdrops[k]++;
          if (k == 1) mfrz[k] = 1'b1;
        end
        if (freeze) mfrz[k] = 1'b1;
      end
    end
    mtag = rst ? 32'd0 : mtag + 32'd1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic [3:0] c, input logic v,
                            input logic [223:0] d, input logic o, input logic [15:0] dr,
                            input logic [127:0] s, input logic f);
    chk($sformatf("u%0d.count", k), 256'(c), 256'(mq[k].size()));
    chk($sformatf("u%0d.rd_valid", k), 256'(v), 256'(mq[k].size() != 0));
    if (mq[k].size() != 0) chk($sformatf("u%0d.rd_data", k), 256'(d), 256'(mq[k][0]));
    chk($sformatf("u%0d.overflow", k), 256'(o), 256'(movf[k]));
    chk($sformatf("u%0d.drops", k), 256'(dr), 256'(mdrops[k]));
    chk($sformatf("u%0d.signature", k), 256'(s), 256'(msig[k]));
    chk($sformatf("u%0d.frozen", k), 256'(f), 256'(mfrz[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_inst(0, count0, rd_valid0, rd_data0, overflow0, drops0, signature0, frozen0);
    check_inst(1, count1, rd_valid1, rd_data1, overflow1, drops1, signature1, frozen1);
  endtask

  task automatic do_reset();
    rst = 1'b1; obs = 1'b0; freeze = 1'b0; rd_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; obs = 1'b0; freeze = 1'b0; rd_ready = 1'b0;
    out_data = '0; cap = '0; mtag = '0;
    for (int k = 0; k < 2; k++) begin
      movf[k] = 1'b0; mdrops[k] = 0; msig[k] = '0; mfrz[k] = 1'b0;
    end

    // Reset state
    do_reset();
    chk("rst.count", 256'(count0), 256'(0));
    chk("rst.rd_valid", 256'(rd_valid0), 256'(0));
    chk("rst.signature", 256'(signature0), 256'(0));
    chk("rst.frozen", 256'(frozen0), 256'(0));

    // Single capture at tag 3
    tick(); tick(); tick();
    obs = 1'b1; out_data = 128'h1; cap = 64'h5;
    tick();
    obs = 1'b0;
    chk("one.count", 256'(count0), 256'(1));
    chk("one.rd_valid", 256'(rd_valid0), 256'(1));
    chk("one.rd_data", 256'(rd_data0), 256'({32'd3, 128'h1, 64'h5}));
    chk("one.signature", 256'(signature0), 256'(128'h1));

    // MISR feedback: the top bit shifted out folds in 0x87
    do_reset();
    obs = 1'b1; out_data = {1'b1, 127'b0};
    tick();
    chk("misr.1", 256'(signature0), 256'({1'b1, 127'b0}));
    out_data = '0;
    tick();
    chk("misr.2", 256'(signature0), 256'(128'h87));
    tick();
    chk("misr.3", 256'(signature0), 256'(128'h10E));
    obs = 1'b0;

    // Overflow: 10 captures into 8 entries, then drain in order
    do_reset();
    obs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out_data = {$urandom, $urandom, $urandom, $urandom}; cap = {$urandom, $urandom};
      tick();
    end
    obs = 1'b0;
    chk("ovf.count", 256'(count0), 256'(8));
    chk("ovf.overflow", 256'(overflow0), 256'(1));
    chk("ovf.drops", 256'(drops0), 256'(2));
    chk("sof.drops", 256'(drops1), 256'(1));
    chk("sof.frozen", 256'(frozen1), 256'(1));
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain.tag", 256'(rd_data0[223:192]), 256'(i));
      chk("sof.drain.tag", 256'(rd_data1[223:192]), 256'(i));
      tick();
    end
    chk("drain.empty", 256'(rd_valid0), 256'(0));
    chk("sof.drain.empty", 256'(rd_valid1), 256'(0));
    rd_ready = 1'b0;

    // Full buffer with simultaneous write and pop
    do_reset();
    obs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rd_ready = 1'b1;
    tick();
    chk("fullrw.count", 256'(count0), 256'(8));
    chk("fullrw.drops", 256'(drops0), 256'(0));
    obs = 1'b0; rd_ready = 1'b0;

    // Freeze together with obs still captures, then obs is ignored
    do_reset();
    obs = 1'b1; freeze = 1'b1;
    tick();
    freeze = 1'b0;
    chk("frz.count", 256'(count0), 256'(1));
    chk("frz.frozen", 256'(frozen0), 256'(1));
    tick();
    chk("frz.ignored", 256'(count0), 256'(1));
    obs = 1'b0;

    // Mid-operation reset discards entries and restarts the tag
    do_reset();
    obs = 1'b1;
    tick(); tick(); tick();
    obs = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.count", 256'(count0), 256'(0));
    chk("mrst.rd_valid", 256'(rd_valid0), 256'(0));
    chk("mrst.signature", 256'(signature0), 256'(0));
    obs = 1'b1; out_data = 128'hABCD;
    tick();
    obs = 1'b0;
    chk("mrst.tag", 256'(rd_data0[223:192]), 256'(0));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 149) == 0);
      obs      = ($urandom_range(0, 3) != 0);
      rd_ready = ($urandom_range(0, 2) == 0);
      freeze   = ($urandom_range(0, 249) == 0);
      out_data = {$urandom, $urandom, $urandom, $urandom};
      cap      = {$urandom, $urandom};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
